// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit.
// Holds the FSM state encodings and the hard-wired zero register index.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    localparam int REG_X0 = 0;

endpackage : hazard_control_unit_pkg

// File: rtl/hazard_control_unit_hz_sat_counter.sv
// Saturating up-counter used for hazard statistics.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears the count
//   inc    add one this cycle (ignored once the count is all ones)
//   count  current count value
module hz_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule : hz_sat_counter

// File: rtl/hazard_control_unit.sv
// Hazard control unit: drives stall, bubble, flush and hold controls for
// load-use, data-memory wait and taken-branch redirect, and keeps saturating
// statistics counters.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   if_id_rs1/rs2, if_id_uses_rs2    source operands of the decode instruction
//   id_ex_rd/mem_read/reg_write      destination info of the EX instruction
//   ex_mem_req, dmem_ready           MEM stage access and completion
//   ex_branch_taken                  taken branch/jump resolved in EX
//   pc_write_en .. mem_wb_bubble     pipeline controls (combinational)
//   mem_timeout_err                  sticky timeout error
//   load_use_cnt/mem_wait_cnt/flush_cnt  saturating statistics
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal flow; a busy memory access freezes and enters MEM_WAIT
// MEM_WAIT | waiting on dmem_ready; frozen until ready, timeout to ERROR
// ERROR    | memory never answered; full freeze until reset
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_reg_write,
    input  logic                  ex_mem_req,
    input  logic                  dmem_ready,
    input  logic                  ex_branch_taken,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_hold,
    output logic                  mem_wb_bubble,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      load_use_cnt,
    output logic [CNT_W-1:0]      mem_wait_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_q;
    logic [WAIT_W-1:0] wait_ctr_q;
    logic              err_q;

    logic load_use;
    logic mem_busy;
    logic frozen;
    logic in_error;
    logic do_branch;
    logic do_load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = id_ex_mem_read && id_ex_reg_write &&
                      (id_ex_rd != REG_ADDR_W'(REG_X0)) &&
                      ((id_ex_rd == if_id_rs1) ||
                       (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

    assign mem_busy = ex_mem_req && !dmem_ready;

    // In MEM_WAIT only dmem_ready releases the freeze; ex_mem_req is held
    // by the pipeline itself and is not re-qualified here.
    assign frozen   = ((state_q == ST_RUN) && mem_busy) ||
                      ((state_q == ST_MEM_WAIT) && !dmem_ready);
    assign in_error = (state_q == ST_ERROR);

    // A branch seen while frozen stays in EX under ex_mem_hold and is acted
    // on naturally in the first unfrozen cycle.
    assign do_branch   = !in_error && !frozen && ex_branch_taken;
    assign do_load_use = !in_error && !frozen && !ex_branch_taken && load_use;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_hold    = 1'b0;
        mem_wb_bubble  = 1'b0;
        if (!rst_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            ex_mem_hold    = 1'b0;
            mem_wb_bubble  = 1'b1;
        end else if (in_error || frozen) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            ex_mem_hold    = 1'b1;
            mem_wb_bubble  = 1'b1;
        end else if (do_branch) begin
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else if (do_load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_ctr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_ctr_q <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_q    <= ST_RUN;
                        wait_ctr_q <= '0;
                    end else if (wait_ctr_q >= WAIT_LIMIT) begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_ctr_q <= wait_ctr_q + WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_ctr_q <= '0;
                end
            endcase
        end
    end

    assign mem_timeout_err = err_q;

    hz_sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_load_use),
        .count (load_use_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frozen),
        .count (mem_wait_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_branch),
        .count (flush_cnt)
    );

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a short timeout and narrow
// counters so that timeout and saturation are reachable quickly.
module tb_hazard_control_unit;

    localparam int RW  = 5;
    localparam int TMO = 4;
    localparam int CW  = 4;

    // Control vector order: {pc_we, ifid_we, flush, bubble, hold, wb_bubble}
    localparam logic [5:0] C_RESET  = 6'b001101;
    localparam logic [5:0] C_NONE   = 6'b110000;
    localparam logic [5:0] C_LU     = 6'b000100;
    localparam logic [5:0] C_FREEZE = 6'b000011;
    localparam logic [5:0] C_BRANCH = 6'b111100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic          if_id_uses_rs2, id_ex_mem_read, id_ex_reg_write;
    logic          ex_mem_req, dmem_ready, ex_branch_taken;
    logic          pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
    logic          ex_mem_hold, mem_wb_bubble, mem_timeout_err;
    logic [CW-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;
    logic [5:0]    ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .if_id_uses_rs2  (if_id_uses_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_reg_write (id_ex_reg_write),
        .ex_mem_req      (ex_mem_req),
        .dmem_ready      (dmem_ready),
        .ex_branch_taken (ex_branch_taken),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout_err (mem_timeout_err),
        .load_use_cnt    (load_use_cnt),
        .mem_wait_cnt    (mem_wait_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign ctrl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
                   ex_mem_hold, mem_wb_bubble};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Load in EX writing rd, decode reading rs1/rs2.
    task automatic set_pipe(input logic ld, input logic [RW-1:0] rd,
                            input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                            input logic use2);
        id_ex_mem_read  = ld;
        id_ex_reg_write = ld;
        id_ex_rd        = rd;
        if_id_rs1       = rs1;
        if_id_rs2       = rs2;
        if_id_uses_rs2  = use2;
    endtask

    task automatic set_mem(input logic req, input logic rdy, input logic br);
        ex_mem_req      = req;
        dmem_ready      = rdy;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_mem(1'b0, 1'b1, 1'b0);
    endtask

    // Inputs change #1 after the rising edge; outputs sampled #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        tick();
        tick();
        chk("reset_lu_cnt", 32'(load_use_cnt), 32'd0);
        chk("reset_err", 32'(mem_timeout_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_ctrl", 32'(ctrl), 32'(C_NONE));

        // load x5 in EX, decode reads rs1=x5: one-cycle stall
        set_pipe(1'b1, 5'd5, 5'd5, 5'd1, 1'b0);
        #1;
        chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        chk("lu_rs1_cnt", 32'(load_use_cnt), 32'd1);
        idle();
        #1;
        chk("lu_after_ctrl", 32'(ctrl), 32'(C_NONE));

        // rd = x0 never hazards
        set_pipe(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        chk("lu_x0_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("lu_x0_cnt", 32'(load_use_cnt), 32'd1);

        // rs2 match only counts when rs2 is used
        set_pipe(1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
        #1;
        chk("lu_rs2_unused", 32'(ctrl), 32'(C_NONE));
        set_pipe(1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
        #1;
        chk("lu_rs2_used", 32'(ctrl), 32'(C_LU));
        tick();
        chk("lu_rs2_cnt", 32'(load_use_cnt), 32'd2);
        idle();

        // memory wait: 3 frozen cycles, then ready
        set_mem(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem_freeze", 32'(ctrl), 32'(C_FREEZE));
            tick();
        end
        set_mem(1'b1, 1'b1, 1'b0);
        #1;
        chk("mem_ready_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("mem_wait_cnt3", 32'(mem_wait_cnt), 32'd3);
        // req low with ready low: only unfrozen if back in RUN
        set_mem(1'b0, 1'b0, 1'b0);
        #1;
        chk("mem_back_run", 32'(ctrl), 32'(C_NONE));
        idle();

        // branch together with load-use: flush wins
        set_pipe(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        set_mem(1'b0, 1'b1, 1'b1);
        #1;
        chk("br_lu_ctrl", 32'(ctrl), 32'(C_BRANCH));
        tick();
        chk("br_lu_flush", 32'(flush_cnt), 32'd1);
        chk("br_lu_lucnt", 32'(load_use_cnt), 32'd2);
        idle();

        // branch during freeze acted on at first unfrozen cycle
        set_mem(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("br_frz_ctrl", 32'(ctrl), 32'(C_FREEZE));
            tick();
        end
        chk("br_frz_noflush", 32'(flush_cnt), 32'd1);
        set_mem(1'b1, 1'b1, 1'b1);
        #1;
        chk("br_unfrz_ctrl", 32'(ctrl), 32'(C_BRANCH));
        tick();
        chk("br_unfrz_flush", 32'(flush_cnt), 32'd2);
        chk("br_unfrz_wait", 32'(mem_wait_cnt), 32'd5);
        idle();

        // load-use counter saturates at 15 (2 + 20 stalls)
        set_pipe(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("lu_saturate", 32'(load_use_cnt), 32'd15);
        idle();

        // timeout: 5 frozen cycles (wait_ctr 1..4) then ERROR
        set_mem(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("tmo_not_yet", 32'(mem_timeout_err), 32'd0);
        tick();
        chk("tmo_err", 32'(mem_timeout_err), 32'd1);
        chk("tmo_wait_cnt", 32'(mem_wait_cnt), 32'd10);
        idle();
        set_mem(1'b0, 1'b1, 1'b1);
        #1;
        chk("err_ctrl", 32'(ctrl), 32'(C_FREEZE));
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", 32'(mem_timeout_err), 32'd1);
        chk("err_no_flush", 32'(flush_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("err_rst_ctrl", 32'(ctrl), 32'(C_RESET));
        tick();
        chk("err_rst_clear", 32'(mem_timeout_err), 32'd0);
        chk("err_rst_flush", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;
        idle();
        #1;
        chk("err_rst_run", 32'(ctrl), 32'(C_NONE));

        // reset mid MEM_WAIT abandons the access
        set_mem(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid_wait_cnt", 32'(mem_wait_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'(ctrl), 32'(C_RESET));
        tick();
        rst_n = 1'b1;
        set_mem(1'b0, 1'b0, 1'b0);
        #1;
        chk("mid_rst_run", 32'(ctrl), 32'(C_NONE));
        chk("mid_rst_wcnt", 32'(mem_wait_cnt), 32'd0);
        chk("mid_rst_lcnt", 32'(load_use_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_control_unit
